// File: rtl/idu_ibuf_if.sv
// Fetch-to-decode bus for the instruction buffer: enqueue side, flush, and head-of-queue side.
// Valid/ready: a transfer happens on a rising edge where valid && ready are both high; neither side may wait for the other before asserting its own signal.
interface idu_ibuf_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            pre_valid;
    logic            pre_ready;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            post_valid;
    logic            post_ready;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;
    logic            sysins;
    logic            ecall;
    logic            mret;
    logic            jal;
    logic            jalr;
    logic            brch;
    logic [CW-1:0]   count;

    modport master (
        output flush, pre_valid, pc, instr, post_ready,
        input  pre_ready, post_valid, head_pc, head_instr,
               sysins, ecall, mret, jal, jalr, brch, count
    );

    modport slave (
        input  flush, pre_valid, pc, instr, post_ready,
        output pre_ready, post_valid, head_pc, head_instr,
               sysins, ecall, mret, jal, jalr, brch, count
    );
endinterface

// File: rtl/idu_ibuf.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular FIFO that stores
// control-class predecode bits alongside each {pc, instr} pair.
module idu_ibuf #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
) (
    input logic     i_clk,
    input logic     i_rst_n,
    idu_ibuf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [5:0]      pd;     // {sysins, ecall, mret, jal, jalr, brch}
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          enq;
    logic          deq;
    entry_t        head;

    function automatic logic [5:0] predecode(input logic [ILEN-1:0] ins);
        logic [6:0] op;
        logic       sys;
        op  = ins[6:0];
        sys = (op == 7'b1110011);
        return {sys,
                sys && (ins[31:7] == 25'd0),
                ins == 32'h3020_0073,
                op == 7'b1101111,
                op == 7'b1100111,
                op == 7'b1100011};
    endfunction

    // A full buffer still accepts when decode drains the head in the same cycle.
    assign bus.pre_ready  = ((cnt < FULL) || bus.post_ready) && !bus.flush;
    assign bus.post_valid = (cnt != '0) && !bus.flush;

    assign enq = bus.pre_valid && bus.pre_ready;
    assign deq = bus.post_valid && bus.post_ready;

    assign head           = mem[rp];
    assign bus.head_pc    = head.pc;
    assign bus.head_instr = head.instr;
    assign bus.sysins     = head.pd[5];
    assign bus.ecall      = head.pd[4];
    assign bus.mret       = head.pd[3];
    assign bus.jal        = head.pd[2];
    assign bus.jalr       = head.pd[1];
    assign bus.brch       = head.pd[0];
    assign bus.count      = cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Entry contents are left stale; only the pointers matter.
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (enq) begin
                mem[wp] <= '{pc: bus.pc, instr: bus.instr, pd: predecode(bus.instr)};
                wp      <= wp + 1'b1;
            end
            if (deq) begin
                rp <= rp + 1'b1;
            end
            if (enq && !deq) begin
                cnt <= cnt + 1'b1;
            end else if (!enq && deq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_idu_ibuf.sv
// Bench for idu_ibuf: directed scenarios plus random traffic, checked against a queue model.
module tb_idu_ibuf;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic  clk;
    logic  rst_n;
    int    n_pass;
    int    n_fail;
    int    n_total;
    item_t exp_q[$];

    idu_ibuf_if #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) bus ();

    idu_ibuf #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference predecode, bit order {sysins, ecall, mret, jal, jalr, brch}.
    function automatic logic [5:0] ref_pd(input logic [31:0] ins);
        logic [5:0] r;
        r = 6'b0;
        case (ins[6:0])
            7'h73: begin
                r[5] = 1'b1;
                if ((ins >> 7) == 32'd0) r[4] = 1'b1;
            end
            7'h6f: r[2] = 1'b1;
            7'h67: r[1] = 1'b1;
            7'h63: r[0] = 1'b1;
            default: r = 6'b0;
        endcase
        if (ins == 32'h3020_0073) r[3] = 1'b1;
        return r;
    endfunction

    function automatic logic [5:0] dut_pd();
        return {bus.sysins, bus.ecall, bus.mret, bus.jal, bus.jalr, bus.brch};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.post_valid, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_pc"}, bus.head_pc, 0);
        check({tag, "_instr"}, bus.head_instr, 0);
        check({tag, "_pd"}, dut_pd(), 0);
        check({tag, "_ready"}, bus.pre_ready, 1);
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at posedge+1; drives inputs, checks at negedge, advances the model at the edge.
    task automatic cycle(input logic fl, input logic pv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic pr);
        logic  exp_ready;
        logic  exp_valid;
        item_t it;
        bus.flush      = fl;
        bus.pre_valid  = pv;
        bus.pc         = pc;
        bus.instr      = ins;
        bus.post_ready = pr;
        @(negedge clk);
        exp_ready = ((exp_q.size() < DEPTH) || pr) && !fl;
        exp_valid = (exp_q.size() != 0) && !fl;
        check("pre_ready", bus.pre_ready, exp_ready);
        check("post_valid", bus.post_valid, exp_valid);
        check("count", bus.count, exp_q.size());
        if (exp_q.size() != 0) begin
            check("head_pc", bus.head_pc, exp_q[0].pc);
            check("head_instr", bus.head_instr, exp_q[0].instr);
            check("head_pd", dut_pd(), ref_pd(exp_q[0].instr));
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_valid && pr) void'(exp_q.pop_front());
            if (pv && exp_ready) begin
                it.pc    = pc;
                it.instr = ins;
                exp_q.push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [6];
        ops = '{7'h73, 7'h6f, 7'h67, 7'h63, 7'h33, 7'h13};
        r = $urandom();
        case ($urandom_range(0, 9))
            0: return 32'h3020_0073;
            1: return 32'h0000_0073;
            2: return r;
            default: return {r[31:7], ops[$urandom_range(0, 5)]};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.pre_valid  = 1'b0;
        bus.pc         = '0;
        bus.instr      = '0;
        bus.post_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Order and predecode with decode stalled, then drain.
        cycle(0, 1, 32'h8000_0000, 32'h0000_0073, 0);
        cycle(0, 1, 32'h8000_0004, 32'h3020_0073, 0);
        cycle(0, 1, 32'h8000_0008, 32'h0000_006f, 0);
        cycle(0, 1, 32'h8000_000c, 32'h0000_8067, 0);
        @(negedge clk);
        check("order_first_ecall", {bus.sysins, bus.ecall, bus.mret}, 3'b110);
        check("order_first_pc", bus.head_pc, 32'h8000_0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, '0, 1);

        // Full: stall accepted only with a concurrent drain.
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h100 + 4 * i, 32'h0000_0013 + (i << 7), 0);
        cycle(0, 1, 32'h110, 32'h0000_0063, 0);
        cycle(0, 1, 32'h110, 32'h0000_0063, 1);
        check("full_count_after_swap", bus.count, 4);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, '0, 1);
        check("full_drained", bus.count, 0);

        // Wrap: streaming through the pointer wrap at occupancy <= 1.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 32'(4 * i), rand_instr(), 1);
            check("wrap_count_le1", bus.count <= 1, 1);
        end
        cycle(0, 0, '0, '0, 1);

        // Flush with three held entries and a concurrent enqueue/dequeue attempt.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h200 + 4 * i, rand_instr(), 0);
        cycle(1, 1, 32'h20c, 32'h0000_006f, 1);
        check("flush_count", bus.count, 0);
        cycle(0, 1, 32'h300, 32'h0000_8067, 0);
        check("flush_new_head_pc", bus.head_pc, 32'h300);

        // Branch decode.
        cycle(0, 1, 32'h304, 32'h00b5_0463, 1);
        check("beq_pd", dut_pd(), 6'b000001);
        cycle(0, 0, '0, '0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            v = $urandom();
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, v & 32'hffff_fffc,
                  rand_instr(), $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset mid-cycle with two entries queued.
        cycle(1, 0, '0, '0, 0);
        cycle(0, 1, 32'h400, 32'h0000_0073, 0);
        cycle(0, 1, 32'h404, 32'h0000_006f, 0);
        #2;
        bus.pre_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 1, 32'h500, 32'h0000_0063, 0);
        cycle(0, 0, '0, '0, 1);
        cycle(0, 0, '0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
